// File: rtl/cache_pkg.sv
// Shared cache definitions: arbiter state encoding, address field ranges and line-address helper.
// Pure declarations; no logic, no latency.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } arb_state_e;

    localparam int ADR_WIDTH_C         = 32;
    localparam int ADR_WORD_OFFSET_LSB = 2;
    localparam int ADR_WORD_OFFSET_MSB = 3;
    localparam int ADR_INDEX_LSB       = 4;
    localparam int ADR_INDEX_MSB       = 9;
    localparam int ADR_TAG_LSB         = 10;
    localparam int ADR_TAG_MSB         = 31;
    localparam int LINE_LSB            = ADR_INDEX_LSB;

    function automatic logic [ADR_WIDTH_C-LINE_LSB-1:0] line_adr(input logic [ADR_WIDTH_C-1:0] adr);
        return adr[ADR_WIDTH_C-1:LINE_LSB];
    endfunction

endpackage

// File: rtl/mem_burst_cnt.sv
// Loadable modulo-WORD_NUM word counter with a beat counter flagging the last word of a burst.
// Load and increment take effect on the next edge; no backpressure of its own.
module mem_burst_cnt #(
    parameter int WORD_NUM  = 4,
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] start_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 last_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] beat_q, beat_d;

    // WORD_NUM is a power of two, so natural overflow gives the modulo wrap.
    always_comb begin
        cnt_d  = cnt_q;
        beat_d = beat_q;
        if (load_i) begin
            cnt_d  = start_i;
            beat_d = '0;
        end else if (inc_i) begin
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            beat_d = beat_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            beat_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            beat_q <= beat_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (beat_q == CNT_WIDTH'(WORD_NUM - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates refill and victim writeback onto one memory port, one uninterruptible 4-word burst at a time.
// One registered grant cycle, then one word per mem_ack_i; requests wait while the other burst runs.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int ADR_WIDTH         = 32,
    parameter int WORD_WIDTH        = 32,
    parameter int WORD_NUM          = 4,
    parameter int WORD_OFFSET_WIDTH = 2,
    parameter int STARVE_MAX        = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rf_req_i,
    input  logic [ADR_WIDTH-1:0]         rf_adr_i,
    output logic                         rf_ack_o,
    output logic [WORD_WIDTH-1:0]        rf_dat_o,
    output logic [WORD_OFFSET_WIDTH-1:0] rf_word_o,
    output logic                         rf_done_o,
    input  logic                         wb_req_i,
    input  logic [ADR_WIDTH-1:0]         wb_adr_i,
    input  logic [WORD_WIDTH-1:0]        wb_dat_i,
    output logic [WORD_OFFSET_WIDTH-1:0] wb_word_o,
    output logic                         wb_ack_o,
    output logic                         wb_done_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [ADR_WIDTH-1:0]         mem_adr_o,
    output logic [WORD_WIDTH-1:0]        mem_dat_o,
    input  logic                         mem_ack_i,
    input  logic [WORD_WIDTH-1:0]        mem_dat_i
);

    localparam int LINE_W   = ADR_WIDTH - WORD_OFFSET_WIDTH - 2;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_e                   state_q, state_d;
    logic [LINE_W-1:0]            line_q, line_d;
    logic [STARVE_W-1:0]          starve_q, starve_d;
    logic                         cnt_load, cnt_inc, cnt_last;
    logic [WORD_OFFSET_WIDTH-1:0] cnt_start, cnt;
    logic                         hazard, wb_first;
    logic                         unused_adr_bits;

    assign unused_adr_bits = ^{rf_adr_i[1:0], wb_adr_i[WORD_OFFSET_WIDTH+1:0]};

    // Same line in flight both ways: the dirty victim must reach memory before it is re-read.
    assign hazard   = (line_adr(rf_adr_i) == line_adr(wb_adr_i));
    assign wb_first = wb_req_i && (!rf_req_i || hazard || (starve_q == STARVE_W'(STARVE_MAX)));
    assign cnt_inc  = (state_q != IDLE) && mem_ack_i;

    mem_burst_cnt #(
        .WORD_NUM  (WORD_NUM),
        .CNT_WIDTH (WORD_OFFSET_WIDTH)
    ) u_burst_cnt (
        .clk     (clk),
        .rst     (rst),
        .load_i  (cnt_load),
        .start_i (cnt_start),
        .inc_i   (cnt_inc),
        .cnt_o   (cnt),
        .last_o  (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        starve_d  = starve_q;
        cnt_load  = 1'b0;
        cnt_start = '0;
        rf_ack_o  = 1'b0;
        rf_dat_o  = '0;
        rf_word_o = '0;
        rf_done_o = 1'b0;
        wb_word_o = '0;
        wb_ack_o  = 1'b0;
        wb_done_o = 1'b0;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        mem_adr_o = '0;
        mem_dat_o = '0;
        case (state_q)
            IDLE: begin
                if (wb_first) begin
                    state_d  = WR_BURST;
                    line_d   = line_adr(wb_adr_i);
                    cnt_load = 1'b1;
                    starve_d = '0;
                end else if (rf_req_i) begin
                    state_d   = RD_BURST;
                    line_d    = line_adr(rf_adr_i);
                    cnt_load  = 1'b1;
                    cnt_start = rf_adr_i[WORD_OFFSET_WIDTH+1:2];
                    if (wb_req_i) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end
            end
            RD_BURST: begin
                mem_req_o = 1'b1;
                mem_adr_o = {line_q, cnt, 2'b00};
                rf_ack_o  = mem_ack_i;
                rf_dat_o  = mem_dat_i;
                rf_word_o = cnt;
                rf_done_o = mem_ack_i && cnt_last;
                if (mem_ack_i && cnt_last) begin
                    state_d = IDLE;
                end
            end
            WR_BURST: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                mem_adr_o = {line_q, cnt, 2'b00};
                mem_dat_o = wb_dat_i;
                wb_word_o = cnt;
                wb_ack_o  = mem_ack_i;
                wb_done_o = mem_ack_i && cnt_last;
                if (mem_ack_i && cnt_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!wb_req_i) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            line_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a simple memory responder with configurable ack latency,
// request sources fed from address lists, and per-cycle logging checked against hand-computed tables.
module tb_cache_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        rf_req_i;
    logic [31:0] rf_adr_i;
    logic        rf_ack_o;
    logic [31:0] rf_dat_o;
    logic [1:0]  rf_word_o;
    logic        rf_done_o;
    logic        wb_req_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [1:0]  wb_word_o;
    logic        wb_ack_o;
    logic        wb_done_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_adr_o;
    logic [31:0] mem_dat_o;
    logic        mem_ack_i;
    logic [31:0] mem_dat_i;

    cache_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .rf_req_i  (rf_req_i),
        .rf_adr_i  (rf_adr_i),
        .rf_ack_o  (rf_ack_o),
        .rf_dat_o  (rf_dat_o),
        .rf_word_o (rf_word_o),
        .rf_done_o (rf_done_o),
        .wb_req_i  (wb_req_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_word_o (wb_word_o),
        .wb_ack_o  (wb_ack_o),
        .wb_done_o (wb_done_o),
        .mem_req_o (mem_req_o),
        .mem_we_o  (mem_we_o),
        .mem_adr_o (mem_adr_o),
        .mem_dat_o (mem_dat_o),
        .mem_ack_i (mem_ack_i),
        .mem_dat_i (mem_dat_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        req, we, ack, rf_ack, wb_ack, rf_done, wb_done;
        logic [31:0] adr, rf_dat, mem_dat;
        logic [1:0]  rf_word, wb_word;
    } rec_t;

    rec_t        lg[$];
    rec_t        acks[$];
    logic [31:0] rf_list[$];
    logic [31:0] wb_list[$];
    logic [31:0] ea[8];
    logic [1:0]  ew[4];
    int          n_vec, n_miss;
    int          ack_lat, wcnt;
    logic        rf_done_seen, wb_done_seen;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock: update sources and responder after the edge, log DUT outputs mid-cycle.
    task automatic cycle();
        rec_t r;
        @(posedge clk);
        #1;
        if (rf_done_seen) begin
            rf_done_seen = 1'b0;
            if (rf_list.size() > 0) rf_adr_i = rf_list.pop_front();
            else rf_req_i = 1'b0;
        end
        if (wb_done_seen) begin
            wb_done_seen = 1'b0;
            if (wb_list.size() > 0) wb_adr_i = wb_list.pop_front();
            else wb_req_i = 1'b0;
        end
        if (mem_req_o) begin
            if (wcnt == ack_lat) begin
                mem_ack_i = 1'b1;
                wcnt      = 0;
            end else begin
                mem_ack_i = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack_i = 1'b0;
            wcnt      = 0;
        end
        mem_dat_i = 32'hD000_0000 | mem_adr_o;
        wb_dat_i  = 32'hA000_0000 | {30'b0, wb_word_o};
        @(negedge clk);
        r.req = mem_req_o;   r.we = mem_we_o;   r.ack = mem_ack_i;
        r.rf_ack = rf_ack_o; r.wb_ack = wb_ack_o;
        r.rf_done = rf_done_o; r.wb_done = wb_done_o;
        r.adr = mem_adr_o;   r.rf_dat = rf_dat_o; r.mem_dat = mem_dat_o;
        r.rf_word = rf_word_o; r.wb_word = wb_word_o;
        lg.push_back(r);
        if (rf_done_o) rf_done_seen = 1'b1;
        if (wb_done_o) wb_done_seen = 1'b1;
    endtask

    task automatic begin_test(input int lat);
        lg.delete();
        ack_lat      = lat;
        rf_done_seen = 1'b0;
        wb_done_seen = 1'b0;
        if (rf_list.size() > 0) begin rf_adr_i = rf_list.pop_front(); rf_req_i = 1'b1; end
        if (wb_list.size() > 0) begin wb_adr_i = wb_list.pop_front(); wb_req_i = 1'b1; end
    endtask

    task automatic run(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(rf_req_i == 1'b0 && wb_req_i == 1'b0 && mem_req_o == 1'b0) && n < budget);
        check_vec({tag, "_timeout"}, 32'(n >= budget), 32'd0);
    endtask

    task automatic collect_acks();
        acks.delete();
        foreach (lg[i]) if (lg[i].ack && lg[i].req) acks.push_back(lg[i]);
    endtask

    initial begin
        rec_t q[$];
        int   pos, nreq, ndone;
        n_vec = 0; n_miss = 0; wcnt = 0; ack_lat = 0;
        rf_done_seen = 1'b0; wb_done_seen = 1'b0;
        rst = 1'b1; rf_req_i = 1'b0; rf_adr_i = '0; wb_req_i = 1'b0; wb_adr_i = '0;
        wb_dat_i = '0; mem_ack_i = 1'b0; mem_dat_i = '0;

        repeat (3) @(negedge clk);
        check_vec("rst_mem_req", mem_req_o, 0);
        check_vec("rst_mem_we",  mem_we_o, 0);
        check_vec("rst_mem_adr", mem_adr_o, 0);
        check_vec("rst_mem_dat", mem_dat_o, 0);
        check_vec("rst_rf_outs", {rf_ack_o, rf_done_o, rf_word_o}, 0);
        check_vec("rst_rf_dat",  rf_dat_o, 0);
        check_vec("rst_wb_outs", {wb_ack_o, wb_done_o, wb_word_o}, 0);
        rst = 1'b0;
        cycle();

        // Refill alone, critical word 2.
        rf_list = '{32'h0000_1238};
        begin_test(0);
        #1 check_vec("t1_grant_cycle_req", mem_req_o, 0);
        run("t1", 40);
        ea[0] = 32'h1238; ea[1] = 32'h123C; ea[2] = 32'h1230; ea[3] = 32'h1234;
        ew[0] = 2'd2; ew[1] = 2'd3; ew[2] = 2'd0; ew[3] = 2'd1;
        collect_acks();
        check_vec("t1_nacks", acks.size(), 4);
        nreq = 0;
        foreach (lg[i]) if (lg[i].req) nreq++;
        check_vec("t1_req_cycles", nreq, 4);
        for (int k = 0; k < 4 && k < acks.size(); k++) begin
            check_vec("t1_adr",    acks[k].adr, ea[k]);
            check_vec("t1_word",   acks[k].rf_word, ew[k]);
            check_vec("t1_we",     acks[k].we, 0);
            check_vec("t1_rf_ack", acks[k].rf_ack, 1);
            check_vec("t1_rf_dat", acks[k].rf_dat, 32'hD000_0000 | ea[k]);
            check_vec("t1_done",   acks[k].rf_done, 32'(k == 3));
        end

        // Writeback alone, ascending from word 0.
        wb_list = '{32'h0000_2004};
        begin_test(0);
        run("t2", 40);
        collect_acks();
        check_vec("t2_nacks", acks.size(), 4);
        for (int k = 0; k < 4 && k < acks.size(); k++) begin
            check_vec("t2_adr",     acks[k].adr, 32'h2000 + 32'(4 * k));
            check_vec("t2_we",      acks[k].we, 1);
            check_vec("t2_wb_word", acks[k].wb_word, 32'(k));
            check_vec("t2_mem_dat", acks[k].mem_dat, 32'hA000_0000 + 32'(k));
            check_vec("t2_wb_ack",  acks[k].wb_ack, 1);
            check_vec("t2_done",    acks[k].wb_done, 32'(k == 3));
        end

        // Both requested, different lines, 3 wait states per word.
        rf_list = '{32'h0000_1000};
        wb_list = '{32'h0000_3000};
        begin_test(3);
        run("t3", 120);
        q.delete();
        foreach (lg[i]) if (lg[i].req) q.push_back(lg[i]);
        check_vec("t3_req_cycles", q.size(), 32);
        for (int i = 0; i < 32 && i < q.size(); i++) begin
            check_vec("t3_adr", q[i].adr, (i < 16 ? 32'h1000 : 32'h3000) + 32'(4 * ((i % 16) / 4)));
            check_vec("t3_we",  q[i].we, 32'(i >= 16));
            check_vec("t3_ack", q[i].ack, 32'(i % 4 == 3));
        end
        pos = -1;
        foreach (lg[i]) if (lg[i].rf_done && pos < 0) pos = i;
        check_vec("t3_rf_done_pos", pos, 15);
        if (lg.size() > 17) begin
            check_vec("t3_gap_req", lg[16].req, 0);
            check_vec("t3_wb_start", {lg[17].req, lg[17].we}, 2'b11);
        end

        // Same line: writeback first, then refill from the critical word.
        rf_list = '{32'h0000_4008};
        wb_list = '{32'h0000_4000};
        begin_test(0);
        run("t4", 60);
        ea[0] = 32'h4000; ea[1] = 32'h4004; ea[2] = 32'h4008; ea[3] = 32'h400C;
        ea[4] = 32'h4008; ea[5] = 32'h400C; ea[6] = 32'h4000; ea[7] = 32'h4004;
        collect_acks();
        check_vec("t4_nacks", acks.size(), 8);
        for (int k = 0; k < 8 && k < acks.size(); k++) begin
            check_vec("t4_adr", acks[k].adr, ea[k]);
            check_vec("t4_we",  acks[k].we, 32'(k < 4));
            check_vec("t4_wb_done", acks[k].wb_done, 32'(k == 3));
            check_vec("t4_rf_done", acks[k].rf_done, 32'(k == 7));
        end

        // Starvation bound: two refills, then the pending writeback.
        rf_list = '{32'h0000_5000, 32'h0000_6000, 32'h0000_7000};
        wb_list = '{32'h0000_8000};
        begin_test(0);
        run("t5", 100);
        collect_acks();
        check_vec("t5_nacks", acks.size(), 16);
        ea[0] = 32'h5000; ea[1] = 32'h6000; ea[2] = 32'h8000; ea[3] = 32'h7000;
        for (int b = 0; b < 4 && 4 * b < acks.size(); b++) begin
            check_vec("t5_burst_adr", acks[4 * b].adr, ea[b]);
            check_vec("t5_burst_we",  acks[4 * b].we, 32'(b == 2));
        end

        // Reset after two refill acks, then restart from the critical word.
        rf_list = '{32'h0000_1238};
        begin_test(0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        if (lg.size() > 2) begin
            check_vec("t6_pre_adr", {lg[0].adr[15:0], lg[1].adr[15:0]}, 32'h1238_123C);
            check_vec("t6_rst_req",  lg[2].req, 0);
            check_vec("t6_rst_done", lg[2].rf_done, 0);
        end
        run("t6", 40);
        collect_acks();
        check_vec("t6_nacks", acks.size(), 6);
        if (acks.size() > 2) check_vec("t6_restart_adr", acks[2].adr, 32'h1238);
        ndone = 0;
        foreach (lg[i]) if (lg[i].rf_done) ndone++;
        check_vec("t6_done_count", ndone, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single word-wide memory port between the 4-way cache's line-refill path and its victim-writeback path. Grants one requester at a time and sequences a full 4-word line burst, with critical-word-first wrap for refills and ascending order for writebacks. Enforces write-before-read ordering when both target the same line, and bounds writeback starvation. Sits between the cache controller (refill FSM, MSHR victim drain) and the memory interface.

## Interface

Parameters:
- ADR_WIDTH, 32, byte address width
- WORD_WIDTH, 32, data word width
- WORD_NUM, 4, words per line; a power of two
- WORD_OFFSET_WIDTH, 2, log2(WORD_NUM); address bits [3:2]
- STARVE_MAX, 2, consecutive refill grants that may defer a pending writeback

Ports:
- clk, in, 1, single clock, rising edge
- rst, in, 1, reset; synchronous, active-high
- rf_req_i, in, 1, refill request; held until rf_done_o
- rf_adr_i, in, ADR_WIDTH, critical-word address; stable while rf_req_i is high
- rf_ack_o, out, 1, refill word valid this cycle
- rf_dat_o, out, WORD_WIDTH, refill word data
- rf_word_o, out, WORD_OFFSET_WIDTH, word index of rf_dat_o
- rf_done_o, out, 1, pulse with the last refill word
- wb_req_i, in, 1, writeback request; held until wb_done_o
- wb_adr_i, in, ADR_WIDTH, victim line address; bits [3:0] ignored
- wb_dat_i, in, WORD_WIDTH, word selected by wb_word_o; valid in the same cycle
- wb_word_o, out, WORD_OFFSET_WIDTH, word index requested from the victim source
- wb_ack_o, out, 1, writeback word accepted by memory
- wb_done_o, out, 1, pulse with the last writeback word
- mem_req_o, out, 1, memory request
- mem_we_o, out, 1, 1 = write, 0 = read
- mem_adr_o, out, ADR_WIDTH, word-aligned address; bits [1:0] = 0
- mem_dat_o, out, WORD_WIDTH, write data (= wb_dat_i)
- mem_ack_i, in, 1, word completed; read data valid on mem_dat_i
- mem_dat_i, in, WORD_WIDTH, read data

## Operation

- FSM states: IDLE, RD_BURST, WR_BURST.
- IDLE arbitration, evaluated each cycle, grant registered:
  - Only one request high: grant that requester.
  - Both high and line addresses equal (bits [31:4]): grant writeback (hazard).
  - Both high, starve_cnt == STARVE_MAX: grant writeback.
  - Both high otherwise: grant refill; starve_cnt increments.
  - starve_cnt clears on any writeback grant, and whenever wb_req_i is low.
- Grant latches the line address and start offset: refill start = rf_adr_i[3:2]; writeback start = 0.
- Bursts cannot be interrupted. The word counter advances by 1 mod WORD_NUM on each mem_ack_i. mem_adr_o = {line, cnt, 2'b00}.
- RD_BURST: rf_ack_o = mem_ack_i, rf_dat_o = mem_dat_i, rf_word_o = cnt. Outputs are combinational from the ack.
- WR_BURST: mem_we_o = 1, wb_word_o = cnt, mem_dat_o = wb_dat_i, wb_ack_o = mem_ack_i.
- The WORD_NUM-th ack asserts done for one cycle, and the FSM returns to IDLE.
- A request that drops mid-burst is a protocol violation. The burst still completes.

## Timing

- Reset values: FSM IDLE, cnt 0, starve_cnt 0, every output 0.
- Grant cycle G (IDLE): mem_req_o = 0. mem_req_o = 1 from G+1.
- mem_req_o, mem_adr_o and mem_we_o stay stable until mem_ack_i. After an ack, the address advances on the next cycle.
- The memory may ack in the same cycle as the request. Minimum burst = 1 grant cycle + WORD_NUM cycles.
- After the last ack, the next cycle is IDLE with mem_req_o = 0. Back-to-back bursts therefore have one idle cycle between them.
- Counter wrap: start 3 gives the sequence 3, 0, 1, 2.
- rst asserted mid-burst: on the next edge go to IDLE with all outputs 0. No done pulse is generated. A re-request restarts from the critical word.

## Structure

- The shared package cache_pkg holds:
  - the state enum (IDLE/RD_BURST/WR_BURST)
  - the ADR_TAG/INDEX/WORD_OFFSET bit-range constants shared with cache4way
  - the line-address extraction function
- Sub-module mem_burst_cnt: a loadable modulo-WORD_NUM counter with start load, ack increment and last-word flag. It is instanced once and shared by both burst types.

## Test plan

- Refill only, rf_adr_i = 0x00001238, ack every cycle:
  - mem_adr_o sequence: 0x1238, 0x123C, 0x1230, 0x1234
  - rf_word_o sequence: 2, 3, 0, 1
  - mem_we_o = 0; rf_done_o asserted with the 4th ack
- Writeback only, wb_adr_i = 0x00002004:
  - mem_adr_o sequence: 0x2000, 0x2004, 0x2008, 0x200C
  - mem_we_o = 1; mem_dat_o matches wb_dat_i for wb_word_o = 0..3
- Simultaneous requests on different lines, rf 0x1000 and wb 0x3000, with 3-cycle ack latency:
  - refill burst first, addresses stable during wait states
  - one IDLE cycle, then the writeback burst
- Hazard, rf 0x4008 and wb 0x4000: writeback is granted first. After wb_done_o, refill starts at 0x4008.
- Starvation, wb held high with continuous refills to distinct lines: two refill grants, then the writeback is granted third.
- rst pulsed after 2 refill acks:
  - next cycle mem_req_o = 0, no rf_done_o
  - a re-request restarts at the critical word
